sweep_capture_bank: RTL and testbench

SWEEP_CAPTURE_BANK -- requirements
Module: sweep_capture_bank

---
 rtl/sweep_capture_bank.sv | 192 +++++++++++++++++++
 tb/tb_sweep_capture_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sweep_capture_bank.sv
// sweep_capture_bank: captures per-channel pulse centres within sync-delimited sweeps.
// Ports: clk, rst (sync, active-high), sens_n (raw active-low sensors), rd_ch/rd_data/rd_hit
//        bank readback, frame_valid/frame_ack handshake, frame_axis, overrun, locked.
module sweep_capture_bank #(
   parameter int NUM_CH    = 4,
   parameter int WIDTH     = 18,
   parameter int OUT_WIDTH = 16,
   parameter int SYNC_MIN  = 32,
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    sens_n,
   input  logic [CW-1:0]        rd_ch,
   output logic [OUT_WIDTH-1:0] rd_data,
   output logic                 rd_hit,
   output logic                 frame_valid,
   input  logic                 frame_ack,
   output logic                 frame_axis,
   output logic                 overrun,
   output logic                 locked
);

   localparam int OW = $clog2(SYNC_MIN + 1);
   localparam logic [OW-1:0]    SMIN = OW'(SYNC_MIN);
   localparam logic [WIDTH-1:0] CMAX = '1;
   localparam logic [WIDTH:0]   OMAX = (WIDTH+1)'((64'd1 << OUT_WIDTH) - 64'd1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [NUM_CH-1:0]    s1, s2, act, act_q, rise, fall;
   logic                 all_on, sync, sat, sweep_end;
   logic [OW-1:0]        on_cnt;
   logic [WIDTH-1:0]     cnt;
   logic                 axis, via_sync, pend_axis;
   logic [WIDTH-1:0]     start_r [NUM_CH];
   logic [WIDTH-1:0]     end_r   [NUM_CH];
   logic [NUM_CH-1:0]    hit, busy;
   logic [OUT_WIDTH-1:0] bank    [NUM_CH];
   logic [NUM_CH-1:0]    bank_hit;

   assign act    = ~s2;
   assign all_on = &act;
   assign rise   = act & ~act_q;
   assign fall   = ~act & act_q;
   // Sync fires on the first all-off cycle after a qualifying all-on run.
   assign sync   = ~all_on && (on_cnt == SMIN);
   assign sat    = (cnt == CMAX);

   function automatic logic [OUT_WIDTH-1:0] mid(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH:0] s;
      s = ({1'b0, a} + {1'b0, b}) >> 1;
      if (s > OMAX) return '1;
      return s[OUT_WIDTH-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= '0;
         s2     <= '0;
         act_q  <= '0;
         on_cnt <= '0;
      end else begin
         s1    <= sens_n;
         s2    <= s1;
         act_q <= act;
         if (!all_on)
            on_cnt <= '0;
         else if (on_cnt != SMIN)
            on_cnt <= on_cnt + OW'(1);
      end
   end

   always_comb begin
      state_nx  = state;
      sweep_end = 1'b0;
      unique case (state)
         IDLE: begin
            if (sync) state_nx = SWEEP;
         end
         SWEEP: begin
            if (sync || sat) begin
               state_nx  = COMMIT;
               sweep_end = 1'b1;
            end
         end
         COMMIT: begin
            state_nx = (via_sync || sync) ? SWEEP : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         axis      <= 1'b0;
         via_sync  <= 1'b0;
         pend_axis <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state <= state_nx;
         if (sync) begin
            cnt    <= '0;
            axis   <= ~axis;
            locked <= 1'b1;
         end else if (state == SWEEP) begin
            if (!sat)
               cnt <= cnt + WIDTH'(1);
            else
               locked <= 1'b0;
         end
         // axis still holds the ending frame's value on this cycle
         if (sweep_end) begin
            via_sync  <= sync;
            pend_axis <= axis;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || state == COMMIT) begin
         for (int i = 0; i < NUM_CH; i++) begin
            start_r[i] <= '0;
            end_r[i]   <= '0;
         end
         hit  <= '0;
         busy <= '0;
      end else if (state == SWEEP) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sweep_end) begin
               // an unfinished pulse is dropped so it cannot leak a centre
               if (busy[i]) begin
                  start_r[i] <= '0;
                  busy[i]    <= 1'b0;
               end
            end else if (!all_on) begin
               if (rise[i] && !hit[i] && !busy[i]) begin
                  busy[i]    <= 1'b1;
                  start_r[i] <= cnt;
               end else if (fall[i] && busy[i]) begin
                  busy[i]  <= 1'b0;
                  end_r[i] <= cnt;
                  hit[i]   <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++)
            bank[i] <= '0;
         bank_hit    <= '0;
         frame_valid <= 1'b0;
         frame_axis  <= 1'b0;
         overrun     <= 1'b0;
      end else if (state == COMMIT) begin
         for (int i = 0; i < NUM_CH; i++)
            bank[i] <= mid(start_r[i], end_r[i]);
         bank_hit    <= hit;
         frame_axis  <= pend_axis;
         frame_valid <= 1'b1;
         if (frame_valid && !frame_ack)
            overrun <= 1'b1;
      end else if (frame_valid && frame_ack) begin
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_hit  = 1'b0;
      if (int'(rd_ch) < NUM_CH) begin
         rd_data = bank[rd_ch];
         rd_hit  = bank_hit[rd_ch];
      end
   end

endmodule

// File: tb/tb_sweep_capture_bank.sv
// tb_sweep_capture_bank: directed checks of sweep_capture_bank at two parameter sets.
// u0 uses defaults; u1 uses WIDTH=8, OUT_WIDTH=4 for saturation cases.
`timescale 1ns/1ps
module tb_sweep_capture_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sens_n;
   logic [1:0]  rd_ch;
   logic        frame_ack;

   logic [15:0] a_data;
   logic        a_hit, a_fv, a_axis, a_ovr, a_lock;
   logic [3:0]  b_data;
   logic        b_hit, b_fv, b_axis, b_ovr, b_lock;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sweep_capture_bank u0 (
      .clk(clk), .rst(rst), .sens_n(sens_n), .rd_ch(rd_ch),
      .rd_data(a_data), .rd_hit(a_hit), .frame_valid(a_fv),
      .frame_ack(frame_ack), .frame_axis(a_axis), .overrun(a_ovr),
      .locked(a_lock)
   );

   sweep_capture_bank #(.WIDTH(8), .OUT_WIDTH(4)) u1 (
      .clk(clk), .rst(rst), .sens_n(sens_n), .rd_ch(rd_ch),
      .rd_data(b_data), .rd_hit(b_hit), .frame_valid(b_fv),
      .frame_ack(frame_ack), .frame_axis(b_axis), .overrun(b_ovr),
      .locked(b_lock)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sel(input int ch);
      rd_ch = 2'(ch);
      #1;
   endtask

   task automatic allon(input int n);
      sens_n = '0;
      cyc(n);
      sens_n = '1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      sens_n = '1;
      rd_ch = '0;
      frame_ack = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(6);

      chk("rst_fv",   32'(a_fv),   0);
      chk("rst_ovr",  32'(a_ovr),  0);
      chk("rst_lock", 32'(a_lock), 0);
      chk("rst_axis", 32'(a_axis), 0);
      chk("rst_data", 32'(a_data), 0);
      chk("rst_hit",  32'(a_hit),  0);

      allon(31);
      cyc(6);
      chk("short_state", 32'(u0.state), 0);
      chk("short_lock",  32'(a_lock),   0);

      // frame 1: sync from IDLE, ch0 100..120, ch1 200..260
      allon(40);
      cyc(101); sens_n[0] = 1'b0;
      cyc(20);  sens_n[0] = 1'b1;
      cyc(80);  sens_n[1] = 1'b0;
      cyc(60);  sens_n[1] = 1'b1;
      cyc(2);
      allon(40);
      cyc(8);
      chk("f1_fv",   32'(a_fv),   1);
      chk("f1_ovr",  32'(a_ovr),  0);
      chk("f1_axis", 32'(a_axis), 1);
      chk("f1_lock", 32'(a_lock), 1);
      sel(0);
      chk("f1_c0", 32'(a_data), 110);
      chk("f1_h0", 32'(a_hit),  1);
      sel(1);
      chk("f1_c1", 32'(a_data), 230);
      chk("f1_h1", 32'(a_hit),  1);
      sel(2);
      chk("f1_h2", 32'(a_hit),  0);
      sel(3);
      chk("f1_h3", 32'(a_hit),  0);

      // frame 2 entered via commit: ch2 10..30, left unacked
      cyc(4);  sens_n[2] = 1'b0;
      cyc(20); sens_n[2] = 1'b1;
      cyc(2);
      allon(40);
      cyc(8);
      chk("f2_fv",   32'(a_fv),   1);
      chk("f2_ovr",  32'(a_ovr),  1);
      chk("f2_axis", 32'(a_axis), 0);
      sel(2);
      chk("f2_c2", 32'(a_data), 20);
      chk("f2_h2", 32'(a_hit),  1);
      sel(0);
      chk("f2_h0", 32'(a_hit),  0);

      frame_ack = 1'b1;
      cyc(1);
      frame_ack = 1'b0;
      chk("ack_fv",  32'(a_fv),  0);
      chk("ack_ovr", 32'(a_ovr), 0);
      sel(2);
      chk("ack_c2", 32'(a_data), 20);

      // reset in the middle of an open pulse
      sens_n[0] = 1'b0;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("mr_fv",    32'(a_fv),     0);
      chk("mr_ovr",   32'(a_ovr),    0);
      chk("mr_lock",  32'(a_lock),   0);
      chk("mr_axis",  32'(a_axis),   0);
      chk("mr_state", 32'(u0.state), 0);
      sel(2);
      chk("mr_data", 32'(a_data), 0);
      chk("mr_hit",  32'(a_hit),  0);
      sens_n[0] = 1'b1;
      cyc(6);
      allon(40);
      cyc(4);
      chk("mr_sync_state", 32'(u0.state), 1);
      chk("mr_sync_axis",  32'(u0.axis),  1);
      chk("mr_sync_fv",    32'(a_fv),     0);
      chk("mr_sync_lock",  32'(a_lock),   1);

      // u1: counter saturation commit, centre saturation, open pulse drop
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(6);
      allon(40);
      cyc(41);  sens_n[0] = 1'b0;
      cyc(20);  sens_n[0] = 1'b1;
      cyc(140); sens_n[1] = 1'b0;
      cyc(70);
      chk("sat_fv",    32'(b_fv),     1);
      chk("sat_lock",  32'(b_lock),   0);
      chk("sat_axis",  32'(b_axis),   1);
      chk("sat_state", 32'(u1.state), 0);
      chk("sat_cnt",   32'(u1.cnt),   255);
      sel(0);
      chk("sat_c0", 32'(b_data), 15);
      chk("sat_h0", 32'(b_hit),  1);
      sel(1);
      chk("sat_c1", 32'(b_data), 0);
      chk("sat_h1", 32'(b_hit),  0);
      sens_n[1] = 1'b1;
      cyc(4);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
